mem_rr_arbiter: RTL and testbench

Round-robin arbiter and access sequencer that shares the single-port `memory` block between `NUM_REQ` bus requesters. Each requester posts a read or write with a level request and holds it until a one-cycle done pulse. The arbiter grants one requester at a time and drives the memory's `paddr_i/pwr_rd_i/penable_i/pwdata_i` pins with a setup/access sequence. It returns `prdata_o` to the winner and aborts stalled accesses with a timeout. It sits between the testbench/initiator agents and the `memory` DUT.

---
 rtl/mem_rr_arbiter_pkg.sv | 18 +
 rtl/mem_rr_arbiter_rr_pick.sv | 37 +++
 rtl/mem_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_rr_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin memory arbiter.
package mem_arb_pkg;

    localparam int NUM_REQ_DEF    = 4;
    localparam int ADDR_WIDTH_DEF = 6;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int TIMEOUT_DEF    = 16;

    localparam logic WRITE = 1'b1;
    localparam logic READ  = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first requester found after last_gnt (with
// wrap-around) wins; returns one-hot grant and its index.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_gnt,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic found_s;

    function automatic logic [IDX_W-1:0] rr_pos(input logic [IDX_W-1:0] last, input int step);
        int sum;
        sum = int'(last) + step;
        return (sum >= NUM_REQ) ? IDX_W'(sum - NUM_REQ) : IDX_W'(sum);
    endfunction

    // Scan requesters in rotated order starting just after the previous winner.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found_s = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (req[rr_pos(last_gnt, k)] && !found_s) begin
                gnt[rr_pos(last_gnt, k)] = 1'b1;
                gnt_idx                  = rr_pos(last_gnt, k);
                found_s                  = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ requesters,
// sequencing each access as SETUP then ACCESS with a bounded wait for pready.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                          pclk_i,
    input  logic                          prst_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            req_wr_rd_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            done_o,
    output logic [NUM_REQ-1:0]            err_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic [ADDR_WIDTH-1:0]         paddr_o,
    output logic                          pwr_rd_o,
    output logic                          penable_o,
    output logic [DATA_WIDTH-1:0]         pwdata_o,
    input  logic [DATA_WIDTH-1:0]         prdata_i,
    input  logic                          pready_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e            state_r;
    logic [IDX_W-1:0]      last_gnt_r;
    logic [IDX_W-1:0]      cur_idx_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [NUM_REQ-1:0]    cand_s;
    logic [NUM_REQ-1:0]    pick_gnt_s;
    logic [IDX_W-1:0]      pick_idx_s;
    logic [ADDR_WIDTH-1:0] pick_addr_s;
    logic [DATA_WIDTH-1:0] pick_wdata_s;
    logic                  pick_wr_s;

    // A requester still holding req in its done cycle has not yet seen the pulse.
    assign cand_s       = req_i & ~done_o;
    assign pick_addr_s  = req_addr_i[pick_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
    assign pick_wdata_s = req_wdata_i[pick_idx_s*DATA_WIDTH +: DATA_WIDTH];
    assign pick_wr_s    = req_wr_rd_i[pick_idx_s];

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req      (cand_s),
        .last_gnt (last_gnt_r),
        .gnt      (pick_gnt_s),
        .gnt_idx  (pick_idx_s)
    );

    // Arbitration FSM with all memory-side and requester-side outputs registered.
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            state_r    <= IDLE;
            last_gnt_r <= IDX_W'(NUM_REQ - 1);
            cur_idx_r  <= '0;
            cnt_r      <= '0;
            gnt_o      <= '0;
            done_o     <= '0;
            err_o      <= '0;
            rdata_o    <= '0;
            paddr_o    <= '0;
            pwr_rd_o   <= 1'b0;
            penable_o  <= 1'b0;
            pwdata_o   <= '0;
        end else begin
            done_o <= '0;
            err_o  <= '0;
            case (state_r)
                IDLE: begin
                    if (|cand_s) begin
                        gnt_o     <= pick_gnt_s;
                        cur_idx_r <= pick_idx_s;
                        paddr_o   <= pick_addr_s;
                        pwdata_o  <= pick_wdata_s;
                        pwr_rd_o  <= pick_wr_s;
                        cnt_r     <= '0;
                        state_r   <= SETUP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SETUP: begin
                    penable_o <= 1'b1;
                    state_r   <= ACCESS;
                end
                ACCESS: begin
                    if (pready_i || (cnt_r == CNT_LAST)) begin
                        if (pready_i && (pwr_rd_o == READ)) begin
                            rdata_o <= prdata_i;
                        end else begin
                            rdata_o <= rdata_o;
                        end
                        done_o     <= gnt_o;
                        err_o      <= pready_i ? '0 : gnt_o;
                        gnt_o      <= '0;
                        penable_o  <= 1'b0;
                        last_gnt_r <= cur_idx_r;
                        state_r    <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    gnt_o     <= '0;
                    penable_o <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: a transaction-level reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_mem_rr_arbiter;

    localparam int NR = 4;
    localparam int AW = 6;
    localparam int DW = 16;
    localparam int TO = 4;

    logic              pclk_i      = 1'b0;
    logic              prst_i      = 1'b0;
    logic [NR-1:0]     req_i       = '0;
    logic [NR-1:0]     req_wr_rd_i = '0;
    logic [NR*AW-1:0]  req_addr_i  = '0;
    logic [NR*DW-1:0]  req_wdata_i = '0;
    logic              pready_i    = 1'b1;
    logic [NR-1:0]     gnt_o, done_o, err_o;
    logic [DW-1:0]     rdata_o, pwdata_o, prdata_i;
    logic [AW-1:0]     paddr_o;
    logic              pwr_rd_o, penable_o;

    logic [DW-1:0] env_mem [64];
    logic [DW-1:0] ref_mem [64];
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int order_q[$];
    int dcyc_q[$];

    mem_rr_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .pclk_i(pclk_i), .prst_i(prst_i), .req_i(req_i), .req_wr_rd_i(req_wr_rd_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .gnt_o(gnt_o),
        .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .paddr_o(paddr_o),
        .pwr_rd_o(pwr_rd_o), .penable_o(penable_o), .pwdata_o(pwdata_o),
        .prdata_i(prdata_i), .pready_i(pready_i)
    );

    always #5 pclk_i = ~pclk_i;

    assign prdata_i = env_mem[paddr_o];

    function automatic logic [DW-1:0] init_word(input int a);
        return (a == 5) ? 16'hA5A5 : 16'(16'h0100 + a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int n, input logic on, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_i       = on ? (req_i | (4'b0001 << n)) : (req_i & ~(4'b0001 << n));
        req_wr_rd_i = wr ? (req_wr_rd_i | (4'b0001 << n)) : (req_wr_rd_i & ~(4'b0001 << n));
        req_addr_i[n*AW +: AW]  = a;
        req_wdata_i[n*DW +: DW] = d;
    endtask

    task automatic wait_done(input int n, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit && at < 0; i++) begin
            @(negedge pclk_i);
            if ((done_o & (4'b0001 << n)) != '0) at = cyc;
        end
        n_cmp++;
        if (at < 0) begin
            n_err++;
            $display("FAIL wait_done%0d: no done within %0d cycles, required one", n, limit);
        end
    endtask

    initial forever begin
        @(posedge pclk_i);
        cyc++;
    end

    // Memory the DUT talks to: combinational read, write on a ready ACCESS cycle.
    initial begin
        logic pend;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        for (int i = 0; i < 64; i++) env_mem[i] = init_word(i);
        forever begin
            @(negedge pclk_i);
            pend = penable_o && pwr_rd_o;
            pa   = paddr_o;
            pd   = pwdata_o;
            @(posedge pclk_i);
            if (!prst_i && pend && pready_i) env_mem[pa] = pd;
        end
    end

    // Reference model: transaction phases counted in edges since the grant.
    logic [NR-1:0] m_gnt = '0, m_done = '0, m_err = '0, m_cand;
    logic          m_pen = 1'b0, m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rdata = '0;
    int m_busy = 0, m_idx = 0, m_last = NR - 1, m_phase = 0, m_wait = 0;

    task automatic m_finish();
        m_done = m_gnt;
        m_gnt  = '0;
        m_pen  = 1'b0;
        m_busy = 0;
        m_last = m_idx;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        forever begin
            @(posedge pclk_i or posedge prst_i);
            if (prst_i) begin
                m_gnt = '0; m_done = '0; m_err = '0; m_pen = 1'b0; m_wr = 1'b0;
                m_addr = '0; m_wdata = '0; m_rdata = '0; m_busy = 0; m_last = NR - 1;
            end else begin
                m_cand = req_i & ~m_done;
                m_done = '0;
                m_err  = '0;
                if (m_busy == 0) begin
                    for (int s = 1; s <= NR; s++) begin
                        if (m_busy == 0 && (m_cand & (4'b0001 << ((m_last + s) % NR))) != '0) begin
                            m_idx   = (m_last + s) % NR;
                            m_busy  = 1;
                            m_phase = 0;
                            m_wait  = 0;
                            m_gnt   = 4'b0001 << m_idx;
                            m_addr  = req_addr_i[m_idx*AW +: AW];
                            m_wdata = req_wdata_i[m_idx*DW +: DW];
                            m_wr    = (req_wr_rd_i & m_gnt) != '0;
                        end
                    end
                end else begin
                    m_phase++;
                    if (m_phase == 1) begin
                        m_pen = 1'b1;
                    end else begin
                        m_wait++;
                        if (pready_i) begin
                            if (m_wr) ref_mem[m_addr] = m_wdata;
                            else m_rdata = ref_mem[m_addr];
                            m_finish();
                        end else if (m_wait == TO) begin
                            m_err = m_gnt;
                            m_finish();
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge pclk_i);
        if (!prst_i) begin
            chk("gnt", 32'(gnt_o), 32'(m_gnt));
            chk("done", 32'(done_o), 32'(m_done));
            chk("err", 32'(err_o), 32'(m_err));
            chk("penable", 32'(penable_o), 32'(m_pen));
            chk("rdata", 32'(rdata_o), 32'(m_rdata));
            chk("gnt_onehot", 32'($onehot0(gnt_o)), 32'd1);
            if (m_gnt != '0) begin
                chk("paddr", 32'(paddr_o), 32'(m_addr));
                chk("pwr_rd", 32'(pwr_rd_o), 32'(m_wr));
                chk("pwdata", 32'(pwdata_o), 32'(m_wdata));
            end
        end
    end

    initial forever begin
        @(negedge pclk_i);
        if (!prst_i) begin
            for (int i = 0; i < NR; i++) begin
                if (done_o == (4'b0001 << i)) begin
                    order_q.push_back(i);
                    dcyc_q.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int at;
        int exp_cont[5];
        int exp_fair[3];
        exp_cont = '{0, 1, 2, 3, 0};
        exp_fair = '{3, 1, 3};

        #1 prst_i = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_penable", 32'(penable_o), 32'd0);
        chk("rst_rdata", 32'(rdata_o), 32'd0);
        chk("rst_paddr", 32'(paddr_o), 32'd0);
        repeat (2) @(negedge pclk_i);
        prst_i = 1'b0;

        // Single read of the preloaded word at address 5.
        @(negedge pclk_i);
        set_req(0, 1'b1, 1'b0, 6'd5, 16'h0000);
        @(negedge pclk_i);
        chk("t1_gnt", 32'(gnt_o), 32'h1);
        chk("t1_setup_pen", 32'(penable_o), 32'd0);
        @(negedge pclk_i);
        chk("t1_access_pen", 32'(penable_o), 32'd1);
        @(negedge pclk_i);
        chk("t1_done", 32'(done_o), 32'h1);
        chk("t1_rdata", 32'(rdata_o), 32'hA5A5);
        chk("t1_gnt_fall", 32'(gnt_o), 32'd0);
        set_req(0, 1'b0, 1'b0, 6'd0, 16'h0000);

        // Write then read back on requester 2; mid-access input changes are ignored.
        @(negedge pclk_i);
        set_req(2, 1'b1, 1'b1, 6'd9, 16'h1234);
        @(negedge pclk_i);
        set_req(2, 1'b1, 1'b1, 6'd0, 16'hFFFF);
        @(negedge pclk_i);
        chk("t2_wr", 32'(pwr_rd_o), 32'd1);
        chk("t2_wdata", 32'(pwdata_o), 32'h1234);
        chk("t2_waddr", 32'(paddr_o), 32'd9);
        @(negedge pclk_i);
        chk("t2_wdone", 32'(done_o), 32'h4);
        set_req(2, 1'b0, 1'b0, 6'd0, 16'h0000);
        @(negedge pclk_i);
        set_req(2, 1'b1, 1'b0, 6'd9, 16'h0000);
        c = cyc;
        wait_done(2, 20, at);
        set_req(2, 1'b0, 1'b0, 6'd0, 16'h0000);
        chk("t2_lat", 32'(at - c), 32'd3);
        chk("t2_rdata", 32'(rdata_o), 32'h1234);

        // Reset asserted in the middle of an ACCESS.
        @(negedge pclk_i);
        set_req(2, 1'b1, 1'b0, 6'd3, 16'h0000);
        repeat (2) @(negedge pclk_i);
        chk("t6_pen_before", 32'(penable_o), 32'd1);
        #2 prst_i = 1'b1;
        #1;
        chk("t6_gnt", 32'(gnt_o), 32'd0);
        chk("t6_pen", 32'(penable_o), 32'd0);
        chk("t6_done", 32'(done_o), 32'd0);
        chk("t6_rdata", 32'(rdata_o), 32'd0);
        chk("t6_pwdata", 32'(pwdata_o), 32'd0);
        order_q.delete();
        dcyc_q.delete();
        @(negedge pclk_i);
        prst_i = 1'b0;

        // Full contention straight after reset: requester 0 first.
        for (int n = 0; n < NR; n++) set_req(n, 1'b1, 1'b0, 6'(n + 10), 16'h0000);
        for (int i = 0; i < 60 && order_q.size() < 5; i++) begin
            @(negedge pclk_i);
            #1;
        end
        req_i = '0;
        chk("cont_count", 32'(order_q.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < order_q.size()) chk("cont_order", 32'(order_q[i]), 32'(exp_cont[i]));
        for (int i = 1; i < 5; i++)
            if (i < dcyc_q.size()) chk("cont_spacing", 32'(dcyc_q[i] - dcyc_q[i-1]), 32'd3);

        // Fairness with a gap: last winner 1, requesters 1 and 3 held.
        @(negedge pclk_i);
        set_req(1, 1'b1, 1'b1, 6'd20, 16'hBEEF);
        wait_done(1, 20, at);
        #1;
        set_req(1, 1'b0, 1'b0, 6'd0, 16'h0000);
        order_q.delete();
        @(negedge pclk_i);
        set_req(1, 1'b1, 1'b1, 6'd21, 16'h1111);
        set_req(3, 1'b1, 1'b0, 6'd7, 16'h0000);
        for (int i = 0; i < 40 && order_q.size() < 3; i++) begin
            @(negedge pclk_i);
            #1;
        end
        req_i = '0;
        chk("fair_count", 32'(order_q.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < order_q.size()) chk("fair_order", 32'(order_q[i]), 32'(exp_fair[i]));

        // Timeout with pready held low.
        @(negedge pclk_i);
        pready_i = 1'b0;
        set_req(0, 1'b1, 1'b0, 6'd5, 16'h0000);
        c = cyc;
        wait_done(0, 30, at);
        chk("to_lat", 32'(at - c), 32'(2 + TO));
        chk("to_err", 32'(err_o), 32'h1);
        chk("to_done", 32'(done_o), 32'h1);
        chk("to_rdata", 32'(rdata_o), 32'h0107);
        set_req(0, 1'b0, 1'b0, 6'd0, 16'h0000);
        pready_i = 1'b1;

        repeat (3) @(negedge pclk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
